inst_loader: RTL and testbench

- AXI-Stream program loader. The write-side initiator for the CPU instruction memory.
- Accepts a program as one AXI-Stream packet of IN_WIDTH-bit beats.
- Packs the beats into DATA_WIDTH-bit instruction words and drives the memory write port (wr_addr/wr_data/wr_en) at sequential addresses from 0.
- Reports the program length and any overflow. Sits between the host-facing control stream and the instruction memory; loads only while the CPU is halted (load_en).

---
 rtl/inst_loader_pkg.sv | 15 +
 rtl/axis_word_packer.sv | 52 +++++
 rtl/inst_loader.sv | 108 ++++++++++
 tb/tb_inst_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the AXI-Stream program loader: loader FSM states
// and the beats-per-word derivation.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } load_state_t;

    function automatic int calc_beats(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

endpackage

// File: rtl/axis_word_packer.sv
// Packs little-endian stream beats into full instruction words; a word is
// presented (combinationally) on the beat that completes it.
module axis_word_packer
    import inst_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_beat,
    input  logic [IN_WIDTH-1:0]   i_data,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_valid,
    output logic                  o_last
);

    localparam int BEATS = calc_beats(DATA_WIDTH, IN_WIDTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0]         r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_pack;
    logic [DATA_WIDTH-1:0] w_word;

    // r_pack only ever holds earlier beats, so unfilled upper lanes stay zero
    always_comb begin
        w_word = r_pack;
        w_word[int'(r_beat_cnt) * IN_WIDTH +: IN_WIDTH] = i_data;
    end

    assign o_word       = w_word;
    assign o_word_valid = i_beat & ((r_beat_cnt == LAST_BEAT) | i_last);
    assign o_last       = i_beat & i_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_pack     <= '0;
        end else if (i_beat) begin
            if (o_word_valid) begin
                r_beat_cnt <= '0;
                r_pack     <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_pack     <= w_word;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// AXI-Stream program loader: writes one packet into instruction memory from
// address 0, reporting program length and overflow.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [IN_WIDTH-1:0]   s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  done,
    output logic                  err_overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    load_state_t           r_state;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic                  w_beat;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_valid;
    logic                  w_last;
    logic                  w_full;
    logic                  w_write;
    logic                  w_drop;

    assign s_tready = load_en & ~rst;
    assign w_beat   = s_tvalid & s_tready;

    axis_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_WIDTH   (IN_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_beat       (w_beat),
        .i_data       (s_tdata),
        .i_last       (s_tlast),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last       (w_last)
    );

    // Once the counter reaches DEPTH further words are dropped, never wrapped
    assign w_full  = (r_word_cnt == DEPTH);
    assign w_write = w_word_valid & (r_state != ST_DRAIN) & ~w_full;
    assign w_drop  = w_word_valid & (r_state != ST_DRAIN) & w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            prog_len     <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (w_write) begin
                wr_en      <= 1'b1;
                wr_addr    <= r_word_cnt[ADDR_WIDTH-1:0];
                wr_data    <= w_word;
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        err_overflow <= 1'b0;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_drop) begin
                        err_overflow <= 1'b1;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                end
                default: r_state <= ST_IDLE;
            endcase

            // tlast ends the packet from any state, overriding the moves above
            if (w_last) begin
                done       <= 1'b1;
                prog_len   <= w_write ? r_word_cnt + 1'b1 : r_word_cnt;
                r_word_cnt <= '0;
                r_state    <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a 4-word memory (ADDR_WIDTH=2) so the
// overflow path is reachable with a short packet.
module tb_inst_loader;

    localparam int AW = 2;
    localparam int DW = 64;
    localparam int IW = 32;

    logic          clk;
    logic          rst;
    logic          load_en;
    logic [IW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [AW:0]   prog_len;
    logic          done;
    logic          err_overflow;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wrLog[$];

    typedef struct {
        logic [IW-1:0] data;
        logic          last;
        logic          expWe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expData;
        logic          expDone;
        logic [AW:0]   expLen;
        logic          expErr;
    } vec_t;

    vec_t vecs[10];

    inst_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .IN_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .prog_len     (prog_len),
        .done         (done),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and done pulse mid-cycle
    always @(negedge clk) begin
        wr_t w;
        if (wr_en) begin
            w.addr = wr_addr;
            w.data = wr_data;
            wrLog.push_back(w);
        end
        if (done) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [IW-1:0] d, input logic l);
        @(negedge clk);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one beat after a random gap and hold it until accepted
    task automatic sendBeat(input logic [IW-1:0] d, input logic l, input int gapMax);
        int  gap;
        bit  acc;
        gap = $urandom_range(gapMax);
        repeat (gap) @(negedge clk);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 100 && !acc; w++) begin
            @(posedge clk);
            acc = s_tready;
        end
        if (!acc) checkOutput("beatAccepted", 64'd0, 64'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] holdAddr;
        logic [DW-1:0] holdData;
        bit            hasBeef;

        vecs[0] = '{32'h11111111, 1'b0, 1'b0, 2'd0, 64'h0,                 1'b0, 3'd0, 1'b0};
        vecs[1] = '{32'h22222222, 1'b0, 1'b1, 2'd0, 64'h2222222211111111, 1'b0, 3'd0, 1'b0};
        vecs[2] = '{32'h33333333, 1'b0, 1'b0, 2'd0, 64'h0,                 1'b0, 3'd0, 1'b0};
        vecs[3] = '{32'h44444444, 1'b1, 1'b1, 2'd1, 64'h4444444433333333, 1'b1, 3'd2, 1'b0};
        vecs[4] = '{32'hAAAAAAAA, 1'b0, 1'b0, 2'd0, 64'h0,                 1'b0, 3'd2, 1'b0};
        vecs[5] = '{32'hBBBBBBBB, 1'b0, 1'b1, 2'd0, 64'hBBBBBBBBAAAAAAAA, 1'b0, 3'd2, 1'b0};
        vecs[6] = '{32'hCCCCCCCC, 1'b1, 1'b1, 2'd1, 64'h00000000CCCCCCCC, 1'b1, 3'd2, 1'b0};
        vecs[7] = '{32'h00000005, 1'b1, 1'b1, 2'd0, 64'h0000000000000005, 1'b1, 3'd1, 1'b0};
        vecs[8] = '{32'h00000007, 1'b0, 1'b0, 2'd0, 64'h0,                 1'b0, 3'd1, 1'b0};
        vecs[9] = '{32'h00000008, 1'b1, 1'b1, 2'd0, 64'h0000000800000007, 1'b1, 3'd1, 1'b0};

        rst      = 1'b1;
        load_en  = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, with load_en already high
        checkOutput("rst.tready",  s_tready,     0);
        checkOutput("rst.wrEn",    wr_en,        0);
        checkOutput("rst.wrAddr",  wr_addr,      0);
        checkOutput("rst.wrData",  wr_data,      0);
        checkOutput("rst.progLen", prog_len,     0);
        checkOutput("rst.done",    done,         0);
        checkOutput("rst.err",     err_overflow, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst.treadyAfter", s_tready, 1);

        // Table: basic, odd tlast, back-to-back 2-word then 1-word packets
        holdAddr = '0;
        holdData = '0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].data, vecs[i].last);
            if (vecs[i].expWe) begin
                holdAddr = vecs[i].expAddr;
                holdData = vecs[i].expData;
            end
            checkOutput($sformatf("v%0d.wrEn", i),    wr_en,        vecs[i].expWe);
            checkOutput($sformatf("v%0d.wrAddr", i),  wr_addr,      holdAddr);
            checkOutput($sformatf("v%0d.wrData", i),  wr_data,      holdData);
            checkOutput($sformatf("v%0d.done", i),    done,         vecs[i].expDone);
            checkOutput($sformatf("v%0d.progLen", i), prog_len,     vecs[i].expLen);
            checkOutput($sformatf("v%0d.err", i),     err_overflow, vecs[i].expErr);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Overflow: 20 beats = 10 words into a 4-word memory
        @(posedge clk);
        #1;
        wrLog.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_tdata  = IW'(i + 1);
            s_tlast  = (i == 19);
            s_tvalid = 1'b1;
            #1;
            checkOutput($sformatf("ovf.tready%0d", i), s_tready, 1);
            @(posedge clk);
            #1;
            if (i == 7) begin
                checkOutput("ovf.lastWrEn", wr_en, 1);
                checkOutput("ovf.lastWrAddr", wr_addr, 3);
            end
            if (i == 9) begin
                checkOutput("ovf.dropWrEn", wr_en, 0);
                checkOutput("ovf.errSet", err_overflow, 1);
                checkOutput("ovf.noEarlyDone", done, 0);
            end
        end
        checkOutput("ovf.done",    done,         1);
        checkOutput("ovf.wrEn",    wr_en,        0);
        checkOutput("ovf.progLen", prog_len,     4);
        checkOutput("ovf.err",     err_overflow, 1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ovf.donePulse", done, 0);
        checkOutput("ovf.writes", wrLog.size(), 4);
        for (int k = 0; k < wrLog.size() && k < 4; k++) begin
            checkOutput($sformatf("ovf.addr%0d", k), wrLog[k].addr, k);
            checkOutput($sformatf("ovf.data%0d", k), wrLog[k].data,
                        {32'(2 * k + 2), 32'(2 * k + 1)});
        end

        // Next packet clears the sticky overflow on its first beat
        applyStimulus(32'h9, 1'b0);
        checkOutput("ovfNext.errCleared", err_overflow, 0);
        applyStimulus(32'hA, 1'b1);
        checkOutput("ovfNext.wrData",  wr_data,  64'h0000000A00000009);
        checkOutput("ovfNext.wrAddr",  wr_addr,  0);
        checkOutput("ovfNext.done",    done,     1);
        checkOutput("ovfNext.progLen", prog_len, 1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Flow control: random gaps plus a 5-cycle load_en hold mid-word
        @(posedge clk);
        #1;
        wrLog.delete();
        doneCount = 0;
        sendBeat(32'h11111111, 1'b0, 2);
        load_en  = 1'b0;
        s_tdata  = 32'h22222222;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("hold.tready%0d", c), s_tready, 0);
            @(negedge clk);
        end
        load_en = 1'b1;
        sendBeat(32'h22222222, 1'b0, 0);
        sendBeat(32'h33333333, 1'b0, 2);
        sendBeat(32'h44444444, 1'b1, 2);
        repeat (3) @(negedge clk);
        checkOutput("flow.writes",  wrLog.size(), 2);
        if (wrLog.size() == 2) begin
            checkOutput("flow.addr0", wrLog[0].addr, 0);
            checkOutput("flow.data0", wrLog[0].data, 64'h2222222211111111);
            checkOutput("flow.addr1", wrLog[1].addr, 1);
            checkOutput("flow.data1", wrLog[1].data, 64'h4444444433333333);
        end
        checkOutput("flow.doneCount", doneCount,    1);
        checkOutput("flow.progLen",   prog_len,     2);
        checkOutput("flow.err",       err_overflow, 0);

        // Reset mid-packet discards the partial word
        @(posedge clk);
        #1;
        wrLog.delete();
        sendBeat(32'hDEADBEEF, 1'b0, 0);
        rst = 1'b1;
        #1;
        checkOutput("midRst.tready",  s_tready, 0);
        checkOutput("midRst.progLen", prog_len, 0);
        checkOutput("midRst.wrData",  wr_data,  0);
        @(negedge clk);
        rst = 1'b0;
        sendBeat(32'h00000001, 1'b0, 0);
        sendBeat(32'h00000002, 1'b1, 0);
        repeat (3) @(negedge clk);
        checkOutput("midRst.writes", wrLog.size(), 1);
        if (wrLog.size() >= 1) begin
            checkOutput("midRst.addr", wrLog[0].addr, 0);
            checkOutput("midRst.data", wrLog[0].data, 64'h0000000200000001);
        end
        hasBeef = 1'b0;
        foreach (wrLog[k])
            if (wrLog[k].data[31:0] == 32'hDEADBEEF || wrLog[k].data[63:32] == 32'hDEADBEEF)
                hasBeef = 1'b1;
        checkOutput("midRst.noStaleWord", hasBeef,  0);
        checkOutput("midRst.progLen",     prog_len, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
